// File: rtl/mem_pkg.sv
// Shared types and helpers for the line-granular main-memory responder.
package mem_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int LINE_WIDTH = 32;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } mem_resp_t;

    // Response payload carried through the delay line; valid travels separately.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } mem_line_t;

    // Depth is a power of two, so masking gives the aliasing wrap.
    function automatic logic [ADDR_WIDTH-1:0] mem_index(input logic [ADDR_WIDTH-1:0] addr,
                                                        input int unsigned depth);
        return addr & ADDR_WIDTH'(depth - 1);
    endfunction

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-latency register chain: a valid shift register plus a matching payload chain.
module mem_delay_pipe #(
    parameter int  MEM_LATENCY = 2,
    parameter type T           = logic
) (
    input  logic clock,
    input  logic reset,
    input  logic vld_in,
    input  T     d_in,
    output logic vld_out,
    output T     d_out
);

    logic [MEM_LATENCY:1] vld_pipe;
    T                     dat_pipe [1:MEM_LATENCY];

    // Payload is cleared too so the idle output reads as zero after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int i = 1; i <= MEM_LATENCY; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= vld_in;
            dat_pipe[1] <= d_in;
            for (int i = 2; i <= MEM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign vld_out = vld_pipe[MEM_LATENCY];
    assign d_out   = dat_pipe[MEM_LATENCY];

endmodule

// File: rtl/mem_main_memory.sv
// Main-memory responder: one command per cycle, responses MEM_LATENCY cycles later, in order.
// Define MEM_WRITE_ACK_EN to make writes return an acknowledgement response as well.
module mem_main_memory
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int DEPTH_LINES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  core_request_read,
    input  logic                  core_request_write,
    input  logic [ADDR_WIDTH-1:0] core_request_addr,
    input  logic [LINE_WIDTH-1:0] core_request_data,
    output logic                  core_response_valid,
    output logic [ADDR_WIDTH-1:0] core_response_addr,
    output logic [LINE_WIDTH-1:0] core_response_data
);

    localparam int IDX_W = $clog2(DEPTH_LINES);

    mem_req_t              req;
    mem_resp_t             resp;
    mem_line_t             line_in;
    mem_line_t             line_out;
    logic                  vld_in;
    logic                  vld_out;
    logic [IDX_W-1:0]      idx;
    logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

    assign req = '{read:  core_request_read,
                   write: core_request_write,
                   addr:  core_request_addr,
                   data:  core_request_data};

    assign idx = IDX_W'(mem_index(req.addr, DEPTH_LINES));

    // Storage is deliberately not reset; committed lines survive a reset pulse.
    always_ff @(posedge clock) begin
        if (reset && req.write) mem[idx] <= req.data;
    end

    // Read samples pre-write contents, so a read followed by a write sees old data.
`ifdef MEM_WRITE_ACK_EN
    assign vld_in = req.read ^ req.write;
`else
    assign vld_in = req.read & ~req.write;
`endif
    assign line_in = '{addr: req.addr,
                       data: req.read ? mem[idx] : req.data};

    mem_delay_pipe #(
        .MEM_LATENCY (MEM_LATENCY),
        .T           (mem_line_t)
    ) u_pipe (
        .clock   (clock),
        .reset   (reset),
        .vld_in  (vld_in),
        .d_in    (line_in),
        .vld_out (vld_out),
        .d_out   (line_out)
    );

    assign resp = '{valid: vld_out, addr: line_out.addr, data: line_out.data};

    assign core_response_valid = resp.valid;
    assign core_response_addr  = resp.addr;
    assign core_response_data  = resp.data;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && req.read && req.write)
            $error("mem_main_memory: read and write in the same cycle, addr %h", req.addr);
    end
`endif

endmodule

// File: tb/tb_mem_main_memory.sv
// Self-checking bench for mem_main_memory: vector table plus reset/ack sequences, queue scoreboard.
module tb_mem_main_memory;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] raddr;
    logic [31:0] rdata;

    mem_main_memory #(.MEM_LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .core_request_read   (rd),
        .core_request_write  (wr),
        .core_request_addr   (addr),
        .core_request_data   (wdata),
        .core_response_valid (rvalid),
        .core_response_addr  (raddr),
        .core_response_data  (rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    // Every cycle either the oldest expectation is due, or the bus must be idle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if (rvalid !== 1'b1 || raddr !== e.addr || rdata !== e.data) begin
                    bad++;
                    $display("FAIL resp cyc=%0d got v=%b a=%h d=%h want v=1 a=%h d=%h",
                             cyc, rvalid, raddr, rdata, e.addr, e.data);
                end
            end else begin
                total++;
                if (rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL idle cyc=%0d got v=%b a=%h d=%h want v=0",
                             cyc, rvalid, raddr, rdata);
                end
            end
        end
    end

    task automatic step(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] e);
        rd = r; wr = w; addr = a; wdata = d;
        if (r && !w) q.push_back('{cyc + LAT, a, e});
`ifdef MEM_WRITE_ACK_EN
        if (w && !r) q.push_back('{cyc + LAT, a, d});
`endif
        @(posedge clock); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_zero(input string name);
        total++;
        if (rvalid !== 1'b0 || raddr !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL %s got v=%b a=%h d=%h want all zero", name, rvalid, raddr, rdata);
        end
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{0, 1, 32'd0,   32'hAAAAAAAA, 32'h0};
        vecs[1]  = '{0, 1, 32'd1,   32'hBBBBBBBB, 32'h0};
        vecs[2]  = '{1, 0, 32'd0,   32'h0,        32'hAAAAAAAA};
        vecs[3]  = '{1, 0, 32'd1,   32'h0,        32'hBBBBBBBB};
        vecs[4]  = '{1, 0, 32'd0,   32'h0,        32'hAAAAAAAA};
        vecs[5]  = '{1, 0, 32'd1,   32'h0,        32'hBBBBBBBB};
        vecs[6]  = '{1, 0, 32'd0,   32'h0,        32'hAAAAAAAA};
        vecs[7]  = '{1, 0, 32'd1,   32'h0,        32'hBBBBBBBB};
        vecs[8]  = '{0, 1, 32'd256, 32'h12345678, 32'h0};
        vecs[9]  = '{1, 0, 32'd0,   32'h0,        32'h12345678};
        vecs[10] = '{1, 0, 32'd256, 32'h0,        32'h12345678};
        vecs[11] = '{0, 1, 32'd5,   32'h00000055, 32'h0};
        vecs[12] = '{1, 0, 32'd5,   32'h0,        32'h00000055};
        vecs[13] = '{1, 0, 32'd5,   32'h0,        32'h00000055};
        vecs[14] = '{0, 1, 32'd5,   32'h00000066, 32'h0};
        vecs[15] = '{1, 0, 32'd5,   32'h0,        32'h00000066};

        // Reset state
        @(posedge clock); #1;
        @(negedge clock);
        check_zero("reset_state");
        @(posedge clock); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // Table: writes, read-back, back-to-back reads, aliasing, RAW/WAR ordering
        for (int i = 0; i < 16; i++)
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
        idle(LAT + 2);

        // Restore line 0 so it holds the pattern again for later reads
        step(1'b0, 1'b1, 32'd0, 32'hAAAAAAAA, '0);
        idle(LAT + 1);

        // Reset one cycle after a read: the response must be dropped
        step(1'b1, 1'b0, 32'd1, '0, 32'hBBBBBBBB);
        reset = 1'b0;
        q.delete();
        @(negedge clock);
        check_zero("reset_mid_op");
        @(posedge clock); #1;
        @(negedge clock);
        check_zero("reset_hold");
        @(posedge clock); #1;
        reset = 1'b1;
        idle(LAT + 2);
        step(1'b1, 1'b0, 32'd1, '0, 32'hBBBBBBBB);
        step(1'b1, 1'b0, 32'd0, '0, 32'hAAAAAAAA);
        idle(LAT + 2);

        // Write acknowledgement (or silence in the default build)
        step(1'b0, 1'b1, 32'd2, 32'hCAFEF00D, '0);
        idle(LAT + 2);
        step(1'b1, 1'b0, 32'd2, '0, 32'hCAFEF00D);
        idle(LAT + 2);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
